// File: rtl/video_slot_arbiter.sv
// ---------------------------------------------------------------------------
// video_slot_arbiter
//
// Owns the single video read slot of the shared memory port and hands it to
// either the ST shifter or the Viking card. Each granted read is tagged with
// its issuer so that the 64-bit data returning DATA_LAT cycles later is
// flagged for the requester that actually asked for it. A change of owner
// requested through viking_enable only takes effect at a frame boundary of
// the current owner (falling vsync), or after SWITCH_TIMEOUT video slots
// if that boundary never arrives.
//
// Parameters:
//   VIDEO_CYCLE     bus_cycle value that is the video slot
//   DATA_LAT        cycles from read to data valid (1..4)
//   SWITCH_TIMEOUT  video slots to wait for vsync before forcing a handover
//
// Ports:
//   clk_32          system clock, the only clock
//   reset           synchronous, active-high
//   bus_cycle       bus phase, advances once per clk_32
//   viking_enable   requested owner (1 = Viking, 0 = shifter)
//   sh_req/sh_addr/sh_vs   shifter request, word address, vsync (active low)
//   vk_req/vk_addr/vk_vs   Viking request, word address, vsync (active low)
//   vaddr, read     registered address / read strobe to memory
//   data            memory read data (routed externally using *_dvalid)
//   sh_ack/vk_ack   request consumed in this slot
//   sh_dvalid/vk_dvalid    data belongs to this requester this cycle
//   owner_viking    current owner
//   switching       handover in progress
//
// Build option:
//   VIDEO_ARB_STEAL_EN  when defined, a slot the owner leaves idle is given
//                       to the non-owner (never while a handover is pending).
// ---------------------------------------------------------------------------
module video_slot_arbiter #(
  parameter logic [1:0]  VIDEO_CYCLE    = 2'd1,
  parameter int          DATA_LAT       = 2,
  parameter logic [15:0] SWITCH_TIMEOUT = 16'd40000
) (
  input  logic        clk_32,
  input  logic        reset,
  input  logic [1:0]  bus_cycle,
  input  logic        viking_enable,
  input  logic        sh_req,
  input  logic [22:0] sh_addr,
  input  logic        sh_vs,
  input  logic        vk_req,
  input  logic [22:0] vk_addr,
  input  logic        vk_vs,
  output logic [22:0] vaddr,
  output logic        read,
  input  logic [63:0] data,
  output logic        sh_ack,
  output logic        vk_ack,
  output logic        sh_dvalid,
  output logic        vk_dvalid,
  output logic        owner_viking,
  output logic        switching
);

  typedef enum logic [1:0] {
    OWN_SH,
    DRAIN_SH,
    OWN_VK,
    DRAIN_VK
  } state_t;

  state_t state, state_next;

  logic        edge_seen, edge_seen_next;
  logic [15:0] slot_cnt, slot_cnt_next;
  logic        sh_vs_d, vk_vs_d;

  // Outstanding reads: valid bit and issuer (1 = Viking) per latency stage.
  logic [DATA_LAT-1:0] pipe_valid;
  logic [DATA_LAT-1:0] pipe_who;

  logic        owner_is_vk;
  logic        draining;
  logic        owner_req;
  logic        other_req;
  logic        owner_fall;
  logic        timed_out;
  logic        pipe_empty;
  logic [1:0]  next_phase;
  logic        pre_slot;
  logic        slot_now;
  logic        grant;
  logic        grant_vk;

  // The data bus itself is routed outside this block; only the tags matter.
  logic        unused_data;
  assign unused_data = ^data;

  assign owner_is_vk = (state == OWN_VK) || (state == DRAIN_VK);
  assign draining    = (state == DRAIN_SH) || (state == DRAIN_VK);
  assign owner_req   = owner_is_vk ? vk_req : sh_req;
  assign other_req   = owner_is_vk ? sh_req : vk_req;
  assign owner_fall  = owner_is_vk ? (vk_vs_d & ~vk_vs) : (sh_vs_d & ~sh_vs);
  assign timed_out   = (slot_cnt >= SWITCH_TIMEOUT);
  assign pipe_empty  = ~|pipe_valid;

  // Outputs are registered, so the grant is decided in the cycle just
  // before the video slot and becomes visible during the slot itself.
  assign next_phase  = bus_cycle + 2'd1;
  assign pre_slot    = (next_phase == VIDEO_CYCLE);
  assign slot_now    = (bus_cycle == VIDEO_CYCLE);

  assign owner_viking = owner_is_vk;
  assign switching    = draining;

  // Slot grant: the owner gets the slot while it owns it or while draining,
  // until a forced handover has been armed by the timeout.
  always_comb begin
    grant    = 1'b0;
    grant_vk = 1'b0;
    if (pre_slot) begin
      if ((!draining || !timed_out) && owner_req) begin
        grant    = 1'b1;
        grant_vk = owner_is_vk;
      end
`ifdef VIDEO_ARB_STEAL_EN
      else if (!draining && other_req) begin
        grant    = 1'b1;
        grant_vk = !owner_is_vk;
      end
`endif
    end
  end

  // Ownership FSM. A handover waits for a vsync falling edge of the current
  // owner (or the timeout) and for every outstanding read to have returned,
  // so data never arrives after the slot changed hands.
  always_comb begin
    state_next     = state;
    edge_seen_next = edge_seen;
    slot_cnt_next  = slot_cnt;
    if (draining) begin
      edge_seen_next = edge_seen | owner_fall;
      if (slot_now && (slot_cnt != 16'hFFFF)) begin
        slot_cnt_next = slot_cnt + 16'd1;
      end
    end else begin
      edge_seen_next = 1'b0;
      slot_cnt_next  = 16'd0;
    end
    case (state)
      OWN_SH: begin
        if (viking_enable) begin
          state_next = DRAIN_SH;
        end
      end
      DRAIN_SH: begin
        if (!viking_enable) begin
          state_next     = OWN_SH;
          edge_seen_next = 1'b0;
          slot_cnt_next  = 16'd0;
        end else if ((edge_seen || timed_out) && pipe_empty) begin
          state_next     = OWN_VK;
          edge_seen_next = 1'b0;
          slot_cnt_next  = 16'd0;
        end
      end
      OWN_VK: begin
        if (!viking_enable) begin
          state_next = DRAIN_VK;
        end
      end
      DRAIN_VK: begin
        if (viking_enable) begin
          state_next     = OWN_VK;
          edge_seen_next = 1'b0;
          slot_cnt_next  = 16'd0;
        end else if ((edge_seen || timed_out) && pipe_empty) begin
          state_next     = OWN_SH;
          edge_seen_next = 1'b0;
          slot_cnt_next  = 16'd0;
        end
      end
      default: begin
        state_next = OWN_SH;
      end
    endcase
  end

  // State register; after reset the owner is whoever viking_enable selects.
  always_ff @(posedge clk_32) begin
    if (reset) begin
      state     <= viking_enable ? OWN_VK : OWN_SH;
      edge_seen <= 1'b0;
      slot_cnt  <= 16'd0;
    end else begin
      state     <= state_next;
      edge_seen <= edge_seen_next;
      slot_cnt  <= slot_cnt_next;
    end
  end

  // Memory strobes, tag pipe and data-valid flags. vaddr keeps its last
  // value on idle slots. Reset empties the pipe so an aborted read never
  // produces a data-valid pulse.
  always_ff @(posedge clk_32) begin
    if (reset) begin
      read       <= 1'b0;
      vaddr      <= 23'd0;
      sh_ack     <= 1'b0;
      vk_ack     <= 1'b0;
      sh_dvalid  <= 1'b0;
      vk_dvalid  <= 1'b0;
      pipe_valid <= '0;
      pipe_who   <= '0;
      sh_vs_d    <= 1'b1;
      vk_vs_d    <= 1'b1;
    end else begin
      read   <= grant;
      sh_ack <= grant & ~grant_vk;
      vk_ack <= grant & grant_vk;
      if (grant) begin
        vaddr <= grant_vk ? vk_addr : sh_addr;
      end
      pipe_valid[0] <= grant;
      pipe_who[0]   <= grant_vk;
      for (int i = 1; i < DATA_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_who[i]   <= pipe_who[i-1];
      end
      sh_dvalid <= pipe_valid[DATA_LAT-1] & ~pipe_who[DATA_LAT-1];
      vk_dvalid <= pipe_valid[DATA_LAT-1] & pipe_who[DATA_LAT-1];
      sh_vs_d   <= sh_vs;
      vk_vs_d   <= vk_vs;
    end
  end

endmodule

// File: doc/video_slot_arbiter.md
# video_slot_arbiter

Sequences the single video read slot of the shared memory interface between the ST shifter and the Viking card. It grants the slot to exactly one owner per bus cycle and tags each read so returned 64-bit data is routed to the requester that issued it. Ownership hands over cleanly, only at a frame boundary, when `viking_enable` changes. It sits between the two video sources and the memory controller's `vaddr`/`read`/`data` port, and replaces a static address/read mux.

## Interface
- `VIDEO_CYCLE`, 2'd1: `bus_cycle` value that is the video slot.
- `DATA_LAT`, 2: clk_32 cycles from `read` asserted to `data` valid (1..4).
- `SWITCH_TIMEOUT`, 16'd40000: maximum video slots to wait for a frame boundary before a forced handover.

Ports:
- `clk_32`  in  1  31.875 MHz system clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `bus_cycle`  in  2  bus phase, advances once per clk_32.
- `viking_enable`  in  1  requested owner: 1 = Viking, 0 = shifter.
- `sh_req`  in  1  shifter requests a read in the next video slot.
- `sh_addr`  in  23  shifter word address.
- `sh_vs`  in  1  shifter vsync, active low.
- `vk_req`  in  1  Viking read request.
- `vk_addr`  in  23  Viking word address.
- `vk_vs`  in  1  Viking vsync, active low.
- `vaddr`  out  23  address to memory.
- `read`  out  1  memory read strobe.
- `data`  in  64  memory read data.
- `sh_ack` / `vk_ack`  out  1  request consumed this slot.
- `sh_dvalid` / `vk_dvalid`  out  1  `data` belongs to this requester this cycle.
- `owner_viking`  out  1  current owner.
- `switching`  out  1  handover in progress.

## Operation
- FSM states: OWN_SH, DRAIN_SH, OWN_VK, DRAIN_VK.
- On reset: state = `viking_enable ? OWN_VK : OWN_SH`. All other outputs 0, tag pipe cleared, timeout counter cleared.
- OWN_x: when `viking_enable` selects the other source, go to DRAIN_x and assert `switching`.
- DRAIN_x: the owner keeps the slot. Leave DRAIN_x when both conditions hold: a falling edge on the owner's vs has been seen since entry, and the tag pipe is empty. The state then becomes OWN of the other source.
- Forced handover: if the timeout counter reaches `SWITCH_TIMEOUT`, stop granting and switch once the pipe is empty. The counter is 16 bits, increments per video slot in DRAIN only, saturates, and clears on leaving DRAIN.
- `viking_enable` reverting during DRAIN_x: return to OWN_x, clear the edge flag and the counter, and deassert `switching`.
- Slot grant: in the clk_32 cycle where `bus_cycle == VIDEO_CYCLE`:
  - If the owner's req is high: `read` = 1, `vaddr` = owner addr, owner ack = 1.
  - Otherwise `read` = 0 and `vaddr` holds its last value.
- Non-owner requests are never acked (except with the steal option below).
- Tag pipe: a shift register `DATA_LAT` deep of {valid, who}. A granted slot pushes {1, who}. The tail drives `sh_dvalid`/`vk_dvalid`.
- Data is delivered to the issuer even if ownership changed meanwhile; the drain rule prevents that case in practice.

## Timing
- `read`, `vaddr`, `*_ack` are registered. They are valid during the slot cycle, so req is sampled one cycle before the slot.
- `*_dvalid` is high exactly `DATA_LAT` cycles after the corresponding `read`, for one cycle.
- At most one grant per 4 clk_32 cycles.
- vs falling-edge detection is registered: 1 cycle latency.
- `owner_viking` changes the cycle after the DRAIN→OWN transition. The first grant to the new owner happens at the next video slot.
- Reset mid-read: the pipe is cleared and no dvalid is emitted for the aborted read.

## Configuration
- `VIDEO_ARB_STEAL_EN` defined: in OWN_x (not DRAIN), a slot the owner leaves idle is granted to the non-owner if its req is high. That read is tagged to the non-owner; only the non-owner's ack and dvalid fire.
- Not defined: idle slots stay idle and the non-owner is never served.

## Test plan
- Reset with `viking_enable` = 1 → `owner_viking` = 1 after reset; all strobes 0; the first `vk_req` is acked in the next slot and `vk_dvalid` fires 2 cycles after `read`.
- Shifter owner, `sh_req` held high, `sh_addr` = 0x012345 → `read` once every 4 cycles with `vaddr` = 0x012345; `vk_req` is ignored.
- Raise `viking_enable` mid-frame → `switching` = 1. The shifter keeps getting slots until `sh_vs` falls and the pipe drains; then `owner_viking` = 1 and `switching` = 0.
- `SWITCH_TIMEOUT` = 8 with `sh_vs` held high → forced handover after 8 slots.
- Toggle `viking_enable` 1→0 during DRAIN_SH → return to OWN_SH, with no handover and no lost dvalid.
- `VIDEO_ARB_STEAL_EN`: owner idle, non-owner req high → non-owner ack and dvalid fire. Without the macro, no ack occurs.
